// File: rtl/rv32i_types_pkg.sv
// Shared RV32I encodings for the memory stage: load/store funct3 values
// and the memory-access controller states.
package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane logic for RV32I loads and stores: byte enables,
// store-data lane shift, load extraction/extension and the misalign flag.
module load_store_align
  import rv32i_types::*;
(
  input  logic        mem_op,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  mbe,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    misalign = mem_op && (((funct3[1:0] == 2'b01) && off[0]) ||
                          ((funct3[1:0] == 2'b10) && (off != 2'b00)));
    wdata    = rs2 << {off, 3'b000};
    case (store_funct3_t'(funct3))
      sb:      mbe = 4'b0001 << off;
      sh:      mbe = 4'b0011 << off;
      sw:      begin
        mbe   = 4'hF;
        wdata = rs2;
      end
      default: mbe = 4'h0;
    endcase

    // The addressed byte/halfword is moved down to bit 0 before extension.
    shifted = rdata >> {off, 3'b000};
    case (load_funct3_t'(funct3))
      lb:      load_data = {{24{shifted[7]}}, shifted[7:0]};
      lbu:     load_data = {24'h0, shifted[7:0]};
      lh:      load_data = {{16{shifted[15]}}, shifted[15:0]};
      lhu:     load_data = {16'h0, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory stage: EX/MEM register, data-cache handshake controller,
// load formatting and writeback presentation with pipeline stall.
module mem_access_stage
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_rs2_out,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  input  logic            dmem_resp,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_read,
  output logic            dmem_write,
  output logic [XLEN-1:0] dmem_address,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_mbe,
  output logic            mem_stall,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign
);

  mem_state_t      state_q, state_d;
  logic            m_valid_q, m_valid_d;
  logic            m_read_q, m_read_d;
  logic            m_write_q, m_write_d;
  logic [2:0]      m_funct3_q, m_funct3_d;
  logic [XLEN-1:0] m_addr_q, m_addr_d;
  logic [XLEN-1:0] m_wdata_q, m_wdata_d;
  logic [4:0]      m_rd_q, m_rd_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            mem_op;
  logic            mis_op;
  logic            issue;
  logic            req;
  logic [3:0]      lane_mbe;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] load_data;

  assign mem_op = m_read_q | m_write_q;
  assign issue  = m_valid_q && mem_op && !mis_op;

  load_store_align u_align (
    .mem_op    (mem_op),
    .funct3    (m_funct3_q),
    .off       (m_addr_q[1:0]),
    .rs2       (m_wdata_q),
    .rdata     (rdata_q),
    .mbe       (lane_mbe),
    .wdata     (lane_wdata),
    .load_data (load_data),
    .misalign  (mis_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      m_valid_q  <= 1'b0;
      m_read_q   <= 1'b0;
      m_write_q  <= 1'b0;
      m_funct3_q <= 3'b000;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_rd_q     <= 5'd0;
      kill_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      m_read_q   <= m_read_d;
      m_write_q  <= m_write_d;
      m_funct3_q <= m_funct3_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_rd_q     <= m_rd_d;
      kill_q     <= kill_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    m_valid_d  = m_valid_q;
    m_read_d   = m_read_q;
    m_write_d  = m_write_q;
    m_funct3_d = m_funct3_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_rd_d     = m_rd_q;
    if (!mem_stall) begin
      m_valid_d  = ex_valid && !flush;
      m_read_d   = ex_mem_read;
      m_write_d  = ex_mem_write;
      m_funct3_d = ex_funct3;
      m_addr_d   = ex_alu_out;
      m_wdata_d  = ex_rs2_out;
      m_rd_d     = ex_rd;
    end
    rdata_d = rdata_q;
    if (dmem_resp && (state_q == BUSY || (state_q == IDLE && issue))) rdata_d = dmem_rdata;
    // A flush seen while a transaction is in flight only suppresses its writeback.
    kill_d = kill_q;
    if (state_q == DONE) kill_d = 1'b0;
    else if (flush && (state_q == BUSY || issue)) kill_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = dmem_resp ? DONE : BUSY;
      BUSY:    if (dmem_resp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req       = 1'b0;
    mem_stall = 1'b0;
    wb_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          req       = 1'b1;
          mem_stall = 1'b1;
        end else begin
          wb_valid = m_valid_q;
        end
      end
      BUSY: begin
        req       = 1'b1;
        mem_stall = 1'b1;
      end
      DONE:    wb_valid = m_valid_q && !kill_q && !flush;
      default: ;
    endcase
    dmem_read    = req && m_read_q;
    dmem_write   = req && m_write_q;
    dmem_address = req ? {m_addr_q[XLEN-1:2], 2'b00} : '0;
    dmem_wdata   = dmem_write ? lane_wdata : '0;
    dmem_mbe     = dmem_write ? lane_mbe : 4'h0;
    wb_rd        = (wb_valid && !m_write_q) ? m_rd_q : 5'd0;
    misalign     = wb_valid && mis_op;
    wb_data      = '0;
    if (wb_valid && !mis_op) begin
      if (m_read_q) wb_data = load_data;
      else if (!m_write_q) wb_data = m_addr_q;
    end
  end

endmodule
